countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer with start/pause, preset load and an alarm state.
// Counts down one step every DIV clk cycles while running; raises a one-cycle done pulse at 0000.
module countdown_timer #(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       key_rst_en,
  input  logic       key_ps_en,
  input  logic       key_ld_en,
  input  logic [3:0] preset1,
  input  logic [3:0] preset2,
  input  logic [3:0] preset3,
  input  logic [3:0] preset4,
  output logic [3:0] num1_out,
  output logic [3:0] num2_out,
  output logic [3:0] num3_out,
  output logic [3:0] num4_out,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [3:0]  presc_q, presc_d;
  logic        done_q, done_d;
  logic        tick;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Ripple borrow from the least significant digit upward; a 0 digit becomes 9 and keeps borrowing.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // The count never decrements from 0000, so it cannot wrap to 9999.
  assign tick = (presc_q == 4'(DIV - 1)) && (count_q != 16'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge key_rst_en) begin
    if (key_rst_en) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = '0;
    done_d  = 1'b0;
    if (key_ld_en) begin
      state_d = IDLE;
      count_d = {clamp_digit(preset1), clamp_digit(preset2),
                 clamp_digit(preset3), clamp_digit(preset4)};
    end else begin
      case (state_q)
        IDLE: begin
          if (key_ps_en && (count_q != 16'd0)) state_d = RUN;
        end
        RUN: begin
          // A pause request wins over a coincident tick.
          if (key_ps_en) begin
            state_d = PAUSE;
          end else if (tick) begin
            count_d = bcd_dec(count_q);
            if (count_d == 16'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 4'd1;
          end
        end
        PAUSE: begin
          if (key_ps_en) state_d = RUN;
        end
        DONE: begin
          if (key_ps_en) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state_q == RUN);
    alarm   = (state_q == DONE);
  end

  assign done     = done_q;
  assign num1_out = count_q[15:12];
  assign num2_out = count_q[11:8];
  assign num3_out = count_q[7:4];
  assign num4_out = count_q[3:0];

endmodule
